// File: rtl/hstl_tx_frame_ctrl.sv
// rtl/hstl_tx_frame_ctrl.sv - frame sequencer driving I/T nets of a tri-state HSTL/DCI pad buffer
// Frames are start bit, LSB-first data, stop bit; pad is released when idle or held.
module hstl_tx_frame_ctrl #(
    parameter int DATA_WIDTH  = 8,
    parameter int TURN_CYCLES = 2
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic [DATA_WIDTH-1:0] IN_DATA,
    input  logic                  IN_VALID,
    output logic                  IN_READY,
    input  logic                  HOLD,
    output logic                  PAD_I,
    output logic                  PAD_T,
    output logic                  BUSY,
    output logic                  ABORT
);

    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH + 1) : 1;
    localparam int TW = (TURN_CYCLES > 0) ? $clog2(TURN_CYCLES + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_TURN,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [BW-1:0]         bit_cnt;
    logic [TW-1:0]         turn_cnt;
    logic                  accept;

    assign IN_READY = ((state == S_IDLE) || (state == S_STOP)) && !HOLD && RST_N;
    assign accept   = IN_VALID && IN_READY;

    // Outputs are registered alongside the state so the pad nets never glitch.
    // The shift register runs one bit ahead of PAD_I because PAD_I is loaded from it.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= S_IDLE;
            shift_reg <= '0;
            bit_cnt   <= '0;
            turn_cnt  <= '0;
            PAD_T     <= 1'b1;
            PAD_I     <= 1'b0;
            BUSY      <= 1'b0;
            ABORT     <= 1'b0;
        end else begin
            ABORT <= 1'b0;
            if (HOLD) begin
                ABORT     <= (state != S_IDLE);
                state     <= S_IDLE;
                shift_reg <= '0;
                bit_cnt   <= '0;
                turn_cnt  <= '0;
                PAD_T     <= 1'b1;
                PAD_I     <= 1'b0;
                BUSY      <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (accept) begin
                            shift_reg <= IN_DATA;
                            BUSY      <= 1'b1;
                            PAD_I     <= 1'b0;
                            if (TURN_CYCLES == 0) begin
                                state <= S_START;
                                PAD_T <= 1'b0;
                            end else begin
                                state    <= S_TURN;
                                turn_cnt <= TW'(TURN_CYCLES - 1);
                                PAD_T    <= 1'b1;
                            end
                        end
                    end
                    S_TURN: begin
                        if (turn_cnt == '0) begin
                            state <= S_START;
                            PAD_T <= 1'b0;
                            PAD_I <= 1'b0;
                        end else begin
                            turn_cnt <= turn_cnt - TW'(1);
                        end
                    end
                    S_START: begin
                        state     <= S_DATA;
                        bit_cnt   <= BW'(DATA_WIDTH - 1);
                        PAD_I     <= shift_reg[0];
                        shift_reg <= shift_reg >> 1;
                    end
                    S_DATA: begin
                        if (bit_cnt == '0) begin
                            state <= S_STOP;
                            PAD_I <= 1'b1;
                        end else begin
                            bit_cnt   <= bit_cnt - BW'(1);
                            PAD_I     <= shift_reg[0];
                            shift_reg <= shift_reg >> 1;
                        end
                    end
                    S_STOP: begin
                        if (accept) begin
                            // Back-to-back word: keep driving, no turnaround.
                            state     <= S_START;
                            shift_reg <= IN_DATA;
                            PAD_I     <= 1'b0;
                        end else begin
                            state <= S_IDLE;
                            PAD_T <= 1'b1;
                            PAD_I <= 1'b0;
                            BUSY  <= 1'b0;
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                        PAD_T <= 1'b1;
                        PAD_I <= 1'b0;
                        BUSY  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hstl_tx_frame_ctrl.sv
// tb/tb_hstl_tx_frame_ctrl.sv - self-checking bench for hstl_tx_frame_ctrl
// Instance 0 uses TURN_CYCLES=2, instance 1 uses TURN_CYCLES=0.
module tb_hstl_tx_frame_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] valid = 2'b00;
    logic [1:0] hold = 2'b00;
    logic [7:0] data [2] = '{8'h00, 8'h00};

    wire pad_t0, pad_i0, busy0, abort0, ready0;
    wire pad_t1, pad_i1, busy1, abort1, ready1;
    wire [1:0] pad_t = {pad_t1, pad_t0};
    wire [1:0] pad_i = {pad_i1, pad_i0};
    wire [1:0] busy  = {busy1, busy0};
    wire [1:0] abort = {abort1, abort0};
    wire [1:0] ready = {ready1, ready0};

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hstl_tx_frame_ctrl #(.DATA_WIDTH(8), .TURN_CYCLES(2)) dut0 (
        .CLK(clk), .RST_N(rst_n), .IN_DATA(data[0]), .IN_VALID(valid[0]),
        .IN_READY(ready0), .HOLD(hold[0]), .PAD_I(pad_i0), .PAD_T(pad_t0),
        .BUSY(busy0), .ABORT(abort0)
    );

    hstl_tx_frame_ctrl #(.DATA_WIDTH(8), .TURN_CYCLES(0)) dut1 (
        .CLK(clk), .RST_N(rst_n), .IN_DATA(data[1]), .IN_VALID(valid[1]),
        .IN_READY(ready1), .HOLD(hold[1]), .PAD_I(pad_i1), .PAD_T(pad_t1),
        .BUSY(busy1), .ABORT(abort1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a queue of the {T,I} values the pad must show on upcoming cycles.
    logic [1:0] exp_buf [2][64];
    int         head [2] = '{0, 0};
    int         cnt [2] = '{0, 0};
    logic [1:0] abort_e = 2'b00;

    function automatic int turn_of(input int d);
        return (d == 0) ? 2 : 0;
    endfunction

    task automatic push(input int d, input logic t, input logic i);
        exp_buf[d][(head[d] + cnt[d]) % 64] = {t, i};
        cnt[d]++;
    endtask

    task automatic model_step(input int d);
        logic acc, was_idle;
        acc      = valid[d] && (cnt[d] <= 1) && !hold[d];
        was_idle = (cnt[d] == 0);
        abort_e[d] = 1'b0;
        if (hold[d]) begin
            abort_e[d] = (cnt[d] != 0);
            cnt[d] = 0;
        end else begin
            if (cnt[d] > 0) begin
                head[d] = (head[d] + 1) % 64;
                cnt[d]--;
            end
            if (acc) begin
                if (was_idle)
                    for (int k = 0; k < turn_of(d); k++) push(d, 1'b1, 1'b0);
                push(d, 1'b0, 1'b0);
                for (int b = 0; b < 8; b++) push(d, 1'b0, data[d][b]);
                push(d, 1'b0, 1'b1);
            end
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < 2; d++) begin
                cnt[d]  = 0;
                head[d] = 0;
            end
            abort_e = 2'b00;
        end else begin
            for (int d = 0; d < 2; d++) model_step(d);
        end
    end

    // Per-instance observations used by the directed literal checks.
    int          busy_n [2], turn_n [2], drive_n [2], run [2], maxrun [2], rdy_n [2], abort_n [2];
    logic [31:0] bits [2];

    task automatic clear_stats();
        for (int d = 0; d < 2; d++) begin
            busy_n[d] = 0; turn_n[d] = 0; drive_n[d] = 0; run[d] = 0;
            maxrun[d] = 0; rdy_n[d] = 0; abort_n[d] = 0; bits[d] = '0;
        end
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            logic et, ei, eb, er;
            et = (cnt[d] > 0) ? exp_buf[d][head[d]][1] : 1'b1;
            ei = (cnt[d] > 0) ? exp_buf[d][head[d]][0] : 1'b0;
            eb = (cnt[d] > 0);
            er = (cnt[d] <= 1) && !hold[d] && rst_n;
            check($sformatf("pad_t%0d", d), 32'(pad_t[d]), 32'(et));
            check($sformatf("pad_i%0d", d), 32'(pad_i[d]), 32'(ei));
            check($sformatf("busy%0d", d), 32'(busy[d]), 32'(eb));
            check($sformatf("abort%0d", d), 32'(abort[d]), 32'(abort_e[d]));
            check($sformatf("in_ready%0d", d), 32'(ready[d]), 32'(er));
            if (busy[d]) busy_n[d]++;
            if (busy[d] && pad_t[d]) turn_n[d]++;
            if (busy[d] && ready[d]) rdy_n[d]++;
            if (abort[d]) abort_n[d]++;
            if (!pad_t[d]) begin
                drive_n[d]++;
                bits[d] = {bits[d][30:0], pad_i[d]};
                run[d]++;
                if (run[d] > maxrun[d]) maxrun[d] = run[d];
            end else begin
                run[d] = 0;
            end
        end
    end

    // Present a word and wait (bounded) for it to be accepted.
    task automatic send(input int d, input logic [7:0] val, input bit keep);
        bit done;
        done = 0;
        @(posedge clk);
        #1;
        valid[d] = 1'b1;
        data[d]  = val;
        for (int n = 0; n < 40 && !done; n++) begin
            @(negedge clk);
            if (ready[d]) done = 1;
        end
        check("accept_timeout", 32'(done), 32'd1);
        @(posedge clk);
        #1;
        if (!keep) valid[d] = 1'b0;
    endtask

    initial begin
        clear_stats();
        repeat (2) @(posedge clk);
        #1;
        check("rst_pad_t", 32'(pad_t0), 32'd1);
        check("rst_pad_i", 32'(pad_i0), 32'd0);
        check("rst_busy", 32'(busy0), 32'd0);
        check("rst_abort", 32'(abort0), 32'd0);
        check("rst_ready", 32'(ready0), 32'd0);
        rst_n = 1'b1;
        #1;
        check("idle_ready", 32'(ready0), 32'd1);

        // Single word 0xA5 with two turnaround cycles.
        clear_stats();
        send(0, 8'hA5, 0);
        repeat (14) @(posedge clk);
        #1;
        check("a5_bits", bits[0] & 32'h3FF, 32'b0101001011);
        check("a5_drive", 32'(drive_n[0]), 32'd10);
        check("a5_turn", 32'(turn_n[0]), 32'd2);
        check("a5_busy", 32'(busy_n[0]), 32'd12);
        check("a5_ready_stop", 32'(rdy_n[0]), 32'd1);

        // Back-to-back 0x0F then 0xF0.
        clear_stats();
        send(0, 8'h0F, 1);
        send(0, 8'hF0, 0);
        repeat (14) @(posedge clk);
        #1;
        check("b2b_bits", bits[0] & 32'hFFFFF, 32'b01111000010000011111);
        check("b2b_run", 32'(maxrun[0]), 32'd20);
        check("b2b_drive", 32'(drive_n[0]), 32'd20);
        check("b2b_turn", 32'(turn_n[0]), 32'd2);

        // No turnaround instance, word 0x00.
        clear_stats();
        send(1, 8'h00, 0);
        check("t0_first_drive", 32'(pad_t1), 32'd0);
        repeat (12) @(posedge clk);
        #1;
        check("t0_bits", bits[1] & 32'h3FF, 32'b0000000001);
        check("t0_turn", 32'(turn_n[1]), 32'd0);
        check("t0_busy", 32'(busy_n[1]), 32'd10);

        // HOLD during the 4th data cycle of 0xFF.
        clear_stats();
        send(0, 8'hFF, 0);
        repeat (6) @(posedge clk);
        #1;
        hold[0] = 1'b1;
        @(posedge clk);
        #1;
        check("hold_pad_t", 32'(pad_t0), 32'd1);
        check("hold_pad_i", 32'(pad_i0), 32'd0);
        check("hold_abort", 32'(abort0), 32'd1);
        check("hold_busy", 32'(busy0), 32'd0);
        check("hold_ready", 32'(ready0), 32'd0);
        @(posedge clk);
        #1;
        check("hold_abort_end", 32'(abort0), 32'd0);
        check("hold_ready2", 32'(ready0), 32'd0);
        @(posedge clk);
        #1;
        hold[0] = 1'b0;
        #1;
        check("hold_release_ready", 32'(ready0), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        check("hold_abort_count", 32'(abort_n[0]), 32'd1);
        check("hold_drive", 32'(drive_n[0]), 32'd5);
        check("hold_bits", bits[0] & 32'h1F, 32'b01111);

        // HOLD with a valid word while idle.
        clear_stats();
        @(posedge clk);
        #1;
        hold[0]  = 1'b1;
        valid[0] = 1'b1;
        data[0]  = 8'h99;
        repeat (3) @(posedge clk);
        #1;
        check("idle_hold_pad_t", 32'(pad_t0), 32'd1);
        hold[0]  = 1'b0;
        valid[0] = 1'b0;
        check("idle_hold_abort", 32'(abort_n[0]), 32'd0);
        check("idle_hold_busy", 32'(busy_n[0]), 32'd0);

        // Asynchronous reset mid-data, then 0x3C with full turnaround.
        clear_stats();
        send(0, 8'h55, 0);
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_pad_t", 32'(pad_t0), 32'd1);
        check("arst_pad_i", 32'(pad_i0), 32'd0);
        check("arst_ready", 32'(ready0), 32'd0);
        check("arst_busy", 32'(busy0), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_stats();
        send(0, 8'h3C, 0);
        repeat (14) @(posedge clk);
        #1;
        check("arst_3c_bits", bits[0] & 32'h3FF, 32'b0001111001);
        check("arst_3c_turn", 32'(turn_n[0]), 32'd2);
        check("arst_3c_drive", 32'(drive_n[0]), 32'd10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

endmodule

// File: doc/hstl_tx_frame_ctrl.md
Name: hstl_tx_frame_ctrl

Overview:
- Sequencer that sits directly upstream of a tri-state HSTL/DCI output pad buffer and generates its data (I) and tri-state control (T) nets.
- Accepts parallel words on a valid/ready interface and serialises each one onto the pad as a frame: start bit, data bits LSB first, stop bit.
- Holds the pad released (T=1) when idle, and inserts bus-turnaround cycles before it first takes the bus.
- A HOLD input forces immediate release and abort, for board-level bus contention control.

Parameters:
- DATA_WIDTH, 8, bits per word; legal range 1..32.
- TURN_CYCLES, 2, released (T=1) cycles between acceptance from IDLE and the start bit; 0 skips the TURN state; legal range 0..15.

Ports:
- CLK  input  1  rising-edge clock.
- RST_N  input  1  asynchronous active-low reset.
- IN_DATA  input  DATA_WIDTH  word to transmit.
- IN_VALID  input  1  IN_DATA is valid.
- IN_READY  output  1  block accepts IN_DATA this cycle.
- HOLD  input  1  synchronous force-release/abort request.
- PAD_I  output  1  data to the pad buffer I input.
- PAD_T  output  1  tri-state control to the pad buffer T input; 1 = released/high-Z.
- BUSY  output  1  high in any state other than IDLE.
- ABORT  output  1  one-cycle pulse when HOLD terminates a frame in progress.

Behaviour:
- Reset (RST_N low, asynchronous): state IDLE; PAD_T=1, PAD_I=0, BUSY=0, ABORT=0, IN_READY=0, shift register and counters cleared.
- PAD_T, PAD_I, BUSY and ABORT are flops loaded from next-state decode. They change only on CLK edges, never glitch, and are aligned with the state register.
- IN_READY = (state==IDLE or state==STOP) and not HOLD and RST_N. It is combinational.
- A word is accepted at an edge where IN_VALID and IN_READY are both 1. IN_DATA is captured into the shift register at that edge.
- IDLE: PAD_T=1, PAD_I=0. On accept, go to TURN, or to START if TURN_CYCLES=0.
- TURN: PAD_T=1, PAD_I=0 for exactly TURN_CYCLES cycles (down-counter), then START.
- START: PAD_T=0, PAD_I=0 for 1 cycle, then DATA.
- DATA: PAD_T=0; PAD_I = shift register bit 0; shift right each cycle; exactly DATA_WIDTH cycles (bit counter), then STOP.
- STOP: PAD_T=0, PAD_I=1 for 1 cycle; IN_READY=1.
  - If accept occurs at the end of STOP: go to START with the new word. No turnaround; PAD_T stays 0 continuously.
  - Otherwise go to IDLE; PAD_T=1 at the next cycle.
- Latency: from the accept edge in IDLE to the first PAD_T=0 cycle is TURN_CYCLES cycles. A frame drives the pad for DATA_WIDTH+2 cycles.
- HOLD=1 sampled at an edge:
  - Next state is IDLE, with PAD_T=1 and PAD_I=0 from that edge.
  - The shift register is cleared and the current word is discarded (no retransmission).
  - ABORT pulses 1 for one cycle if the state was TURN, START, DATA or STOP; no pulse if the state was IDLE.
  - HOLD has priority over acceptance: IN_READY is 0 while HOLD=1.
- HOLD held high: remain in IDLE with PAD_T=1. Normal operation resumes on the first edge with HOLD=0.
- IN_VALID deasserted while not ready: no effect. IN_DATA changes while not accepted: ignored.
- Reset asserted mid-frame: outputs go to reset values immediately (asynchronous) and the frame is lost. After deassertion, state is IDLE and a new frame begins with the full turnaround.
- Counters are sized to hold DATA_WIDTH and TURN_CYCLES exactly; no wrap-around within a frame.

Test Plan:
- Single word, DATA_WIDTH=8, TURN_CYCLES=2, IN_DATA=0xA5 accepted from IDLE:
  - PAD_T=1 for 2 cycles;
  - then PAD_T=0 with PAD_I sequence 0,1,0,1,0,0,1,0,1,1 (start, LSB-first data, stop);
  - then PAD_T=1, PAD_I=0; BUSY high for 12 cycles; IN_READY=1 only in the STOP cycle.
- Back-to-back, 0x0F then 0xF0 (second presented during STOP):
  - PAD_T stays 0 for 20 consecutive cycles, with no turnaround between frames;
  - PAD_I = 0,1,1,1,1,0,0,0,0,1,0,0,0,0,0,1,1,1,1,1.
- TURN_CYCLES=0, IN_DATA=0x00: PAD_T=0 starting the cycle after the accept edge; PAD_I = 0 for 9 cycles, then 1.
- HOLD asserted during the 4th DATA cycle of 0xFF: at the next edge PAD_T=1 and PAD_I=0; ABORT=1 for exactly one cycle; BUSY=0; IN_READY=0 until HOLD drops, then 1.
- RST_N pulsed low mid-DATA: PAD_T=1 and IN_READY=0 asynchronously, without waiting for a clock edge. After release, IN_DATA=0x3C is accepted and runs a full TURN (2 cycles) plus frame.
- HOLD=1 with IN_VALID=1 in IDLE: no accept, PAD_T stays 1, no ABORT pulse.
